// File: rtl/frame_step_pacer.sv
// Shared clock-to-frame prescaler feeding NUM_CH independent frame dividers.
// Each channel emits a one-cycle step every div_q frames, continuous or one-shot.
module frame_step_pacer #(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned FRAME_RATE      = 60,
  parameter int unsigned TICK_COUNT      = CLOCK_FREQUENCY / FRAME_RATE,
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned DIV_W           = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_CH*DIV_W-1:0]   ch_div,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH-1:0]         ch_oneshot,
  input  logic [NUM_CH-1:0]         ch_load,
  output logic                      frame_tick,
  output logic [NUM_CH-1:0]         step,
  output logic [NUM_CH-1:0]         ch_done
);

  localparam int unsigned PW = $clog2(TICK_COUNT);
  localparam logic [PW-1:0] PLast = PW'(TICK_COUNT - 1);

  logic [PW-1:0] presc_q;
  logic          tick_q;
  logic          tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else if (enable) begin
      presc_q <= (presc_q == PLast) ? '0 : presc_q + PW'(1);
      tick_q  <= (presc_q == PLast);
    end else begin
      tick_q  <= 1'b0;
    end
  end

  assign frame_tick = tick_q;
  // Channels only consume ticks while running so a freeze leaves them untouched.
  assign tick = tick_q & enable;

  typedef enum logic [1:0] {StIdle, StRun, StDone} ch_state_e;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] slice;
    logic [DIV_W-1:0] div_last;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             step_q, step_d;
    ch_state_e        state_q, state_d;

    assign slice    = ch_div[g*DIV_W +: DIV_W];
    assign div_last = div_q - DIV_W'(1);

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      step_d  = 1'b0;
      if (ch_load[g]) begin
        cnt_d   = '0;
        div_d   = slice;
        state_d = (ch_en[g] && slice != '0) ? StRun : StIdle;
      end else if (enable) begin
        if (!ch_en[g]) begin
          state_d = StIdle;
          cnt_d   = '0;
          div_d   = slice;
        end else begin
          unique case (state_q)
            StIdle: begin
              div_d = slice;
              cnt_d = '0;
              if (slice != '0) state_d = StRun;
            end
            StRun: begin
              if (div_q == '0) begin
                state_d = StIdle;
              end else if (tick) begin
                if (cnt_q == div_last) begin
                  step_d = 1'b1;
                  cnt_d  = '0;
                  // New divisor only takes effect at a step boundary.
                  div_d  = slice;
                  if (ch_oneshot[g]) state_d = StDone;
                end else begin
                  cnt_d = cnt_q + DIV_W'(1);
                end
              end
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
          endcase
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        div_q   <= '0;
        step_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        div_q   <= div_d;
        step_q  <= step_d;
      end
    end

    assign step[g]    = step_q;
    assign ch_done[g] = (state_q == StDone);
  end

endmodule

// File: doc/frame_step_pacer.md
Name: frame_step_pacer

Overview:
Multi-channel successor to the single-speed frame pacer. It combines a parametrised clock-to-frame prescaler with NUM_CH independent frame dividers. Each channel emits a one-cycle step pulse every ch_div frames, in continuous or one-shot mode. It sits between the system clock and the object-movement/plot FSMs, so several sprites (coins, player, obstacles) can move at different programmable speeds from one shared frame tick.

Parameters:
CLOCK_FREQUENCY, 50000000, system clock frequency in Hz
FRAME_RATE, 60, frame ticks per second
TICK_COUNT, CLOCK_FREQUENCY/FRAME_RATE, clocks per frame (derived; must be >= 2)
NUM_CH, 4, number of independent step channels
DIV_W, 4, width of each per-channel frames-per-step divisor

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
enable  in  1  global run; low freezes prescaler and all channels
ch_div  in  NUM_CH*DIV_W  frames per step, channel i at [i*DIV_W +: DIV_W]
ch_en  in  NUM_CH  per-channel enable
ch_oneshot  in  NUM_CH  1 = emit a single step then stop; 0 = continuous
ch_load  in  NUM_CH  one-cycle pulse: restart channel, latch new divisor
frame_tick  out  1  one-cycle pulse per frame
step  out  NUM_CH  one-cycle step pulse per channel
ch_done  out  NUM_CH  one-shot channel has fired and is parked

Behaviour:
- Reset (async, any time): prescaler = 0, all channel counters = 0, latched divisors = 0, all channels IDLE. frame_tick, step and ch_done = 0.
- Prescaler:
  - Counter width is $clog2(TICK_COUNT).
  - While enable = 1, it counts 0..TICK_COUNT-1 and then wraps to 0.
  - frame_tick is registered. It is high for exactly one cycle, in the cycle after the counter holds TICK_COUNT-1. This gives a period of exactly TICK_COUNT clocks.
  - enable = 0: counter holds its value, frame_tick = 0, no channel state changes.
- Per-channel state: cnt[DIV_W], div_q[DIV_W], FSM {IDLE, RUN, DONE}.
- ch_load[i] (highest priority after reset):
  - cnt <- 0, div_q <- ch_div slice.
  - Next state is RUN if ch_en[i] and the slice is nonzero, else IDLE.
  - A frame_tick in the same cycle is ignored for that channel.
- ch_en[i] = 0: state -> IDLE, cnt <- 0, step[i] = 0, ch_done[i] = 0.
- IDLE -> RUN:
  - Occurs when ch_en[i] = 1 and div_q != 0.
  - div_q is refreshed from ch_div every cycle while in IDLE.
- RUN, on frame_tick:
  - If cnt == div_q-1: step[i] = 1 on the next cycle, cnt <- 0, div_q <- current ch_div slice (divisor changes take effect at the step boundary).
  - Otherwise cnt <- cnt+1.
  - Step period = div_q frames; the first step comes div_q frames after entering RUN.
- RUN, one-shot: after the step fires, state -> DONE and ch_done[i] = 1 from the same cycle as the step. Leave DONE only via ch_load or ch_en = 0.
- RUN, latched divisor becomes 0: the channel returns to IDLE with no step.
- Latency: step[i] is high in the cycle after frame_tick, one cycle wide. It never asserts without a preceding frame_tick, except via the load rule, which cannot produce a step.
- Simultaneous steps on multiple channels are independent and are all emitted in the same cycle.
- DIV_W arithmetic: cnt never exceeds div_q-1. Maximum period is 2^DIV_W-1 frames; there is no overflow.

Test Plan:
Set CLOCK_FREQUENCY=100, FRAME_RATE=10 (TICK_COUNT=10), NUM_CH=4, DIV_W=4 for all scenarios.
1. Reset release, enable=1 -> frame_tick pulses at cycles 10, 20, 30 after the first counting edge; each pulse one cycle wide; assert reset mid-count -> all outputs 0 immediately (async).
2. ch_div = {15,6,2,1}, all ch_en=1, continuous -> ch0 steps every frame, ch1 every 2nd, ch2 every 6th, ch3 every 15th; each step exactly 1 clk after frame_tick.
3. ch1 oneshot, div=3 -> single step after 3rd frame_tick, ch_done[1]=1 and held; no further steps; ch_load[1] -> ch_done clears, next step 3 frames later.
4. Change ch_div[0] from 6 to 2 mid-period -> current 6-frame period completes, following periods are 2 frames; ch_load in the same cycle as frame_tick -> that tick is ignored, count restarts.
5. enable=0 for 25 clk mid-frame -> no frame_tick or step during the gap; the prescaler resumes from its held value, so the next tick is delayed by exactly 25 clk.
6. ch_div=0 or ch_en=0 on one channel -> step stays 0 for that channel while the other channels are unaffected; dropping ch_en mid-period then raising it again -> count restarts from 0.
